// File: rtl/time_register_pkg.sv
// Shared types for the MM:SS countdown time register: controller states,
// the BCD digit limit and the four-digit BCD time word.
package time_register_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_COUNT = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } bcd_time_t;

  function automatic logic time_is_zero(input bcd_time_t t);
    return (t == '0);
  endfunction

  // Minutes as a binary value (0..99 for valid BCD digits).
  function automatic logic [7:0] minutes_of(input bcd_time_t t);
    return ({4'd0, t.min_tens} * 8'd10) + {4'd0, t.min_ones};
  endfunction

endpackage

// File: rtl/time_register_bcd_digit_down.sv
// Single BCD digit decrementer: subtracts the incoming borrow and wraps to a
// caller-supplied value when the digit underflows, raising borrow-out.
module bcd_digit_down
  import time_register_pkg::*;
(
  input  bcd_t digit_i,
  input  logic borrow_i,
  input  bcd_t wrap_i,
  output bcd_t digit_o,
  output logic borrow_o
);

  // Decrement by the borrow; a zero digit wraps and passes the borrow on.
  always_comb begin
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (borrow_i) begin
      if (digit_i == 4'd0) begin
        digit_o  = wrap_i;
        borrow_o = 1'b1;
      end else begin
        digit_o  = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_register.sv
// MM:SS countdown time register for a keypad-driven timer.
// Digits are shifted in from the keypad stage, start/cancel control the
// countdown, and a 1 Hz tick decrements the BCD time until it reaches 00:00.
// Optional build macro TIME_REGISTER_NORMALIZE_EN folds 60+ seconds into the
// minutes when a count is started; without it, entered seconds are counted
// down as-is.
module time_register
  import time_register_pkg::*;
#(
  parameter int unsigned MAX_SEC_TENS = 5,
  parameter int unsigned MAX_MIN      = 99
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [3:0] digit,
  input  logic       loadn,
  input  logic       pgt,
  input  logic       start,
  input  logic       cancel,
  input  logic       tick,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done
);

  localparam bcd_t       SEC_TENS_WRAP = 4'(MAX_SEC_TENS);
  localparam logic [7:0] MAX_MIN_L     = 8'(MAX_MIN);

  state_e    state_q, state_d;
  bcd_time_t time_q, time_d;
  logic      pgt_q;
  logic      running_q, running_d;
  logic      done_q, done_d;

  logic      key_strobe;
  bcd_time_t shift_base;
  bcd_time_t start_time;
  logic [7:0] start_min;
  logic      start_ok;

  bcd_t      dec_so, dec_st, dec_mo, dec_mt;
  logic      bor_so, bor_st, bor_mo, bor_mt;
  bcd_time_t dec_time;

  // A key is taken on the rising edge of pgt while loadn flags a valid key;
  // non-decimal codes are dropped here.
  assign key_strobe = pgt & ~pgt_q & ~loadn & (digit <= BCD_MAX);

  // One-second decrement chain, least significant digit first.
  bcd_digit_down u_sec_ones (
    .digit_i  (time_q.sec_ones),
    .borrow_i (1'b1),
    .wrap_i   (BCD_MAX),
    .digit_o  (dec_so),
    .borrow_o (bor_so)
  );

  bcd_digit_down u_sec_tens (
    .digit_i  (time_q.sec_tens),
    .borrow_i (bor_so),
    .wrap_i   (SEC_TENS_WRAP),
    .digit_o  (dec_st),
    .borrow_o (bor_st)
  );

  bcd_digit_down u_min_ones (
    .digit_i  (time_q.min_ones),
    .borrow_i (bor_st),
    .wrap_i   (BCD_MAX),
    .digit_o  (dec_mo),
    .borrow_o (bor_mo)
  );

  bcd_digit_down u_min_tens (
    .digit_i  (time_q.min_tens),
    .borrow_i (bor_mo),
    .wrap_i   (BCD_MAX),
    .digit_o  (dec_mt),
    .borrow_o (bor_mt)
  );

  assign dec_time = '{min_tens: dec_mt, min_ones: dec_mo,
                      sec_tens: dec_st, sec_ones: dec_so};

`ifdef TIME_REGISTER_NORMALIZE_EN
  // Fold 60 or more seconds into one extra minute so counting starts from a
  // canonical MM:SS; the minute total is checked against the limit afterwards.
  always_comb begin
    start_time = time_q;
    start_min  = minutes_of(time_q);
    if (time_q.sec_tens >= 4'd6) begin
      start_time.sec_tens = time_q.sec_tens - 4'd6;
      start_min           = start_min + 8'd1;
      if (time_q.min_ones == BCD_MAX) begin
        start_time.min_ones = 4'd0;
        start_time.min_tens = time_q.min_tens + 4'd1;
      end else begin
        start_time.min_ones = time_q.min_ones + 4'd1;
      end
    end
  end
`else
  assign start_time = time_q;
  assign start_min  = minutes_of(time_q);
`endif

  assign start_ok = ((state_q == ST_ENTRY) || (state_q == ST_PAUSE)) &&
                    !time_is_zero(time_q) && (start_min <= MAX_MIN_L);

  // A completed count is wiped before a new digit goes in.
  assign shift_base = (state_q == ST_DONE) ? '0 : time_q;

  // Next state and time, prioritised cancel > start > tick > key strobe.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    if (cancel) begin
      if (state_q == ST_COUNT) begin
        state_d = ST_PAUSE;
      end else begin
        state_d = ST_IDLE;
        time_d  = '0;
      end
    end else if (start) begin
      if (start_ok) begin
        state_d = ST_COUNT;
        time_d  = start_time;
      end
    end else if (tick && (state_q == ST_COUNT)) begin
      // A borrow out of the top digit would mean wrapping past 00:00; hold.
      if (!bor_mt) begin
        time_d = dec_time;
        if (time_is_zero(dec_time)) begin
          state_d = ST_DONE;
        end
      end
    end else if (key_strobe &&
                 ((state_q == ST_IDLE) || (state_q == ST_ENTRY) ||
                  (state_q == ST_DONE))) begin
      time_d  = {shift_base.min_ones, shift_base.sec_tens,
                 shift_base.sec_ones, digit};
      state_d = ST_ENTRY;
    end
  end

  // Status flags are registered from the next state so they line up with it.
  always_comb begin
    running_d = (state_d == ST_COUNT);
    done_d    = (state_d == ST_DONE);
  end

  // State, time and key-edge registers; clear acts immediately.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      time_q    <= '0;
      pgt_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      pgt_q     <= pgt;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign min_tens = time_q.min_tens;
  assign min_ones = time_q.min_ones;
  assign sec_tens = time_q.sec_tens;
  assign sec_ones = time_q.sec_ones;
  assign running  = running_q;
  assign done     = done_q;

endmodule

// File: tb/tb_time_register.sv
// Directed and randomized bench for time_register, checked against a
// behavioural minutes/seconds model of the countdown timer.
module tb_time_register;

  localparam int MAX_SEC_TENS = 5;
  localparam int MAX_MIN      = 99;

  localparam int S_IDLE  = 0;
  localparam int S_ENTRY = 1;
  localparam int S_COUNT = 2;
  localparam int S_PAUSE = 3;
  localparam int S_DONE  = 4;

  logic       clock  = 1'b0;
  logic       clear  = 1'b1;
  logic [3:0] digit  = 4'd0;
  logic       loadn  = 1'b1;
  logic       pgt    = 1'b0;
  logic       start  = 1'b0;
  logic       cancel = 1'b0;
  logic       tick   = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, done;

  int n_assert = 0;
  int n_fail   = 0;

  int m_state;
  int m_min;
  int m_sec;
  bit m_pgt_prev;

  time_register #(
    .MAX_SEC_TENS (MAX_SEC_TENS),
    .MAX_MIN      (MAX_MIN)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .digit    (digit),
    .loadn    (loadn),
    .pgt      (pgt),
    .start    (start),
    .cancel   (cancel),
    .tick     (tick),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .done     (done)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  function automatic logic [15:0] disp_of(input int mn, input int sc);
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "/disp"},    disp(),       disp_of(m_min, m_sec));
    chk({tag, "/running"}, 16'(running), 16'(m_state == S_COUNT));
    chk({tag, "/done"},    16'(done),    16'(m_state == S_DONE));
  endtask

  task automatic model_reset();
    m_state    = S_IDLE;
    m_min      = 0;
    m_sec      = 0;
    m_pgt_prev = 1'b0;
  endtask

  // Timer behaviour expressed in whole minutes and seconds.
  task automatic model_step();
    bit strobe;
    int nm;
    int ns;
    int v;
    strobe     = pgt && !m_pgt_prev && !loadn && (digit <= 4'd9);
    m_pgt_prev = pgt;
    if (cancel) begin
      if (m_state == S_COUNT) m_state = S_PAUSE;
      else begin
        m_state = S_IDLE;
        m_min   = 0;
        m_sec   = 0;
      end
    end else if (start) begin
      nm = m_min;
      ns = m_sec;
`ifdef TIME_REGISTER_NORMALIZE_EN
      if (ns >= 60) begin
        nm = nm + 1;
        ns = ns - 60;
      end
`endif
      if ((m_state == S_ENTRY || m_state == S_PAUSE) &&
          (m_min * 60 + m_sec) != 0 && nm <= MAX_MIN) begin
        m_state = S_COUNT;
        m_min   = nm;
        m_sec   = ns;
      end
    end else if (tick && m_state == S_COUNT) begin
      if (m_sec > 0) m_sec = m_sec - 1;
      else begin
        m_min = m_min - 1;
        m_sec = MAX_SEC_TENS * 10 + 9;
      end
      if (m_min == 0 && m_sec == 0) m_state = S_DONE;
    end else if (strobe && (m_state == S_IDLE || m_state == S_ENTRY || m_state == S_DONE)) begin
      if (m_state == S_DONE) begin
        m_min = 0;
        m_sec = 0;
      end
      v       = ((m_min * 100 + m_sec) * 10 + int'(digit)) % 10000;
      m_min   = v / 100;
      m_sec   = v % 100;
      m_state = S_ENTRY;
    end
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clock);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    tick   = 1'b0;
    check_model(tag);
  endtask

  task automatic press(input logic [3:0] d);
    digit = d;
    loadn = 1'b0;
    pgt   = 1'b1;
    step("key");
    pgt   = 1'b0;
    loadn = 1'b1;
    step("key_rel");
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_model("reset");
    clear = 1'b0;
    step("idle");

    // Key entry and an invalid digit.
    press(4'd1); press(4'd3); press(4'd0);
    chk("entry_0130", disp(), 16'h0130);
    press(4'hC);
    chk("bad_digit", disp(), 16'h0130);

    // Full 90-second countdown with one extra tick.
    start = 1'b1; step("start_0130");
    for (int i = 1; i <= 91; i++) begin
      tick = 1'b1;
      step("tick");
      if (i == 31) chk("tick31_0059", disp(), 16'h0059);
      if (i == 89) chk("tick89_running", 16'(running), 16'd1);
      if (i == 90) begin
        chk("tick90_done", 16'(done), 16'd1);
        chk("tick90_running", 16'(running), 16'd0);
        chk("tick90_disp", disp(), 16'h0000);
      end
    end
    chk("tick91_disp", disp(), 16'h0000);

    // Pause, ignored key, resume to done.
    cancel = 1'b1; step("cancel_done");
    press(4'd0); press(4'd5);
    start = 1'b1; step("start_0005");
    tick = 1'b1; step("t1");
    tick = 1'b1; step("t2");
    chk("at_0003", disp(), 16'h0003);
    cancel = 1'b1; step("pause");
    chk("pause_running", 16'(running), 16'd0);
    press(4'd7);
    chk("pause_key_ignored", disp(), 16'h0003);
    start = 1'b1; step("resume");
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      step("t_resume");
    end
    chk("resume_done", 16'(done), 16'd1);

    // Key in DONE restarts entry from zero.
    press(4'd4);
    chk("done_key_0004", disp(), 16'h0004);

    // Cancel beats tick; start beats tick.
    cancel = 1'b1; step("to_idle");
    press(4'd1); press(4'd0);
    start = 1'b1; step("start_0010");
    cancel = 1'b1; tick = 1'b1; step("cancel_tick");
    chk("cancel_tick_0010", disp(), 16'h0010);
    start = 1'b1; tick = 1'b1; step("start_tick_pause");
    chk("start_tick_pause_0010", disp(), 16'h0010);
    start = 1'b1; tick = 1'b1; step("start_tick_count");
    chk("start_tick_count_0010", disp(), 16'h0010);
    tick = 1'b1; step("tick_0009");
    chk("tick_0009", disp(), 16'h0009);
    cancel = 1'b1; step("c1");
    cancel = 1'b1; step("c2");

    // Start with zero time is ignored.
    press(4'd0);
    start = 1'b1; step("start_zero");
    chk("start_zero_running", 16'(running), 16'd0);

    // Fifth digit drops the oldest.
    cancel = 1'b1; step("c3");
    for (int d = 1; d <= 5; d++) press(4'(d));
    chk("five_digits_2345", disp(), 16'h2345);

    // Asynchronous clear mid-count, with pgt held high through it.
    cancel = 1'b1; step("c4");
    press(4'd4); press(4'd2);
    start = 1'b1; step("start_0042");
    pgt   = 1'b1;
    loadn = 1'b0;
    digit = 4'd7;
    #3;
    clear = 1'b1;
    #1;
    model_reset();
    chk("clear_disp", disp(), 16'h0000);
    chk("clear_running", 16'(running), 16'd0);
    chk("clear_done", 16'(done), 16'd0);
    @(posedge clock);
    #1;
    check_model("in_clear");
    clear = 1'b0;
    step("pgt_held");
    chk("pgt_held_0007", disp(), 16'h0007);
    pgt   = 1'b0;
    loadn = 1'b1;
    step("pgt_rel");

    // Seconds-tens above the wrap limit.
    cancel = 1'b1; step("c5");
    press(4'd9); press(4'd0);
    chk("entry_0090", disp(), 16'h0090);
    start = 1'b1; step("start_0090");
`ifdef TIME_REGISTER_NORMALIZE_EN
    chk("norm_0130", disp(), 16'h0130);
`else
    chk("raw_0090", disp(), 16'h0090);
`endif
    tick = 1'b1; step("tick_0090");
`ifdef TIME_REGISTER_NORMALIZE_EN
    chk("norm_0129", disp(), 16'h0129);
`else
    chk("raw_0089", disp(), 16'h0089);
`endif

    // Randomized traffic against the model.
    cancel = 1'b1; step("c6");
    for (int i = 0; i < 800; i++) begin
      cancel = ($urandom_range(0, 39) == 0);
      start  = ($urandom_range(0, 9) == 0);
      tick   = ($urandom_range(0, 2) == 0);
      pgt    = 1'($urandom_range(0, 1));
      loadn  = ($urandom_range(0, 5) == 0);
      digit  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 11)) : 4'd0;
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
